// File: rtl/usb_txn_sequencer.sv
// Host-side USB transaction sequencer: sends token/data/handshake packets to the encoder,
// waits for the device response, retries failed attempts and tracks the DATA0/DATA1 toggle.
module usb_txn_sequencer #(
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 64,
  parameter int IPG_CYC     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_in,
  input  logic [6:0]  req_addr,
  input  logic [3:0]  req_endp,
  input  logic [63:0] req_data,
  output logic        pkt_avail,
  output logic [7:0]  pid_in,
  output logic [6:0]  addr_in,
  output logic [3:0]  endp_in,
  output logic [63:0] data_in,
  input  logic        enc_last,
  input  logic        rx_pkt_valid,
  input  logic [7:0]  rx_pid,
  input  logic [63:0] rx_data,
  input  logic        rx_crc_ok,
  output logic        done,
  output logic [1:0]  status,
  output logic [63:0] resp_data,
  output logic [3:0]  dbg_state
);

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = (IPG_CYC > 1) ? $clog2(IPG_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_TOKEN, S_TOK_WAIT, S_GAP, S_DATA,
    S_DATA_WAIT, S_WAIT_RESP, S_HS, S_HS_WAIT, S_DONE
  } state_t;

  state_t        state, state_n, pend, pend_n;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry_cnt;
  logic          toggle;
  logic          is_in_q;
  logic [6:0]    addr_q;
  logic [3:0]    endp_q;
  logic [63:0]   data_q;
  logic          fail, ack_ok, in_ok;
  logic [1:0]    fin_status;

  // Request handshake: a request is taken on any clock edge where req_valid and
  // req_ready are both high; req_ready is high only while the sequencer is idle.
  assign req_ready = (state == S_IDLE);
  assign pkt_avail = (state == S_TOKEN) || (state == S_DATA) || (state == S_HS);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_comb begin
    state_n    = state;
    pend_n     = pend;
    fail       = 1'b0;
    ack_ok     = 1'b0;
    in_ok      = 1'b0;
    fin_status = 2'b00;
    case (state)
      S_IDLE:      if (req_valid) state_n = S_TOKEN;
      S_TOKEN:     state_n = S_TOK_WAIT;
      S_TOK_WAIT: begin
        if (enc_last) begin
          if (is_in_q) begin
            state_n = S_WAIT_RESP;
          end else begin
            state_n = S_GAP;
            pend_n  = S_DATA;
          end
        end
      end
      S_GAP:       if (gap_cnt == GW'(IPG_CYC - 1)) state_n = pend;
      S_DATA:      state_n = S_DATA_WAIT;
      S_DATA_WAIT: if (enc_last) state_n = S_WAIT_RESP;
      S_WAIT_RESP: begin
        // A packet arriving in the expiry cycle is still honoured.
        if (rx_pkt_valid) begin
          if (rx_pid == PID_STALL) begin
            state_n    = S_DONE;
            fin_status = 2'b01;
          end else if (!is_in_q && rx_pid == PID_ACK) begin
            state_n = S_DONE;
            ack_ok  = 1'b1;
          end else if (is_in_q && rx_crc_ok &&
                       (rx_pid == PID_DATA0 || rx_pid == PID_DATA1)) begin
            in_ok   = 1'b1;
            state_n = S_GAP;
            pend_n  = S_HS;
          end else begin
            fail = 1'b1;
          end
        end else if (timer == TW'(TIMEOUT_CYC)) begin
          fail = 1'b1;
        end
      end
      S_HS:        state_n = S_HS_WAIT;
      S_HS_WAIT:   if (enc_last) state_n = S_DONE;
      S_DONE:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
    if (fail) begin
      if (retry_cnt == RW'(MAX_RETRY)) begin
        state_n    = S_DONE;
        fin_status = 2'b10;
      end else begin
        state_n = S_GAP;
        pend_n  = S_TOKEN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pend      <= S_IDLE;
      gap_cnt   <= '0;
      timer     <= '0;
      retry_cnt <= '0;
      toggle    <= 1'b0;
      is_in_q   <= 1'b0;
      addr_q    <= '0;
      endp_q    <= '0;
      data_q    <= '0;
      pid_in    <= '0;
      addr_in   <= '0;
      endp_in   <= '0;
      data_in   <= '0;
      status    <= '0;
      resp_data <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      gap_cnt <= (state == S_GAP && state_n == S_GAP) ? gap_cnt + GW'(1) : '0;
      if (state != S_WAIT_RESP)        timer <= '0;
      else if (timer != TW'(TIMEOUT_CYC)) timer <= timer + TW'(1);
      if (state == S_IDLE && req_valid) begin
        is_in_q   <= req_is_in;
        addr_q    <= req_addr;
        endp_q    <= req_endp;
        data_q    <= req_data;
        retry_cnt <= '0;
        pid_in    <= req_is_in ? PID_IN : PID_OUT;
        addr_in   <= req_addr;
        endp_in   <= req_endp;
      end
      if (fail && retry_cnt != RW'(MAX_RETRY)) retry_cnt <= retry_cnt + RW'(1);
      if (state == S_DONE) retry_cnt <= '0;
      if (ack_ok) toggle <= ~toggle;
      if (in_ok)  resp_data <= rx_data;
      if (state_n == S_DONE && state != S_DONE) status <= fin_status;
      // Packet fields are loaded on entry to the send state and held through the wait.
      if (state == S_GAP && state_n == S_TOKEN) begin
        pid_in  <= is_in_q ? PID_IN : PID_OUT;
        addr_in <= addr_q;
        endp_in <= endp_q;
      end
      if (state == S_GAP && state_n == S_DATA) begin
        pid_in  <= toggle ? PID_DATA1 : PID_DATA0;
        data_in <= data_q;
      end
      if (state == S_GAP && state_n == S_HS) pid_in <= PID_ACK;
    end
  end

endmodule
